// File: rtl/vga_pkg.sv
// Shared screen geometry, coordinate type and PS/2 mouse packet field indices
// used by the cursor tracker and the draw/click logic.
package vga_pkg;

   localparam int HOR_PIXELS = 800;
   localparam int VER_PIXELS = 600;

   typedef logic [11:0] coord_t;

   localparam int PS2_BTN_L = 0;
   localparam int PS2_BTN_R = 1;
   localparam int PS2_SYNC  = 3;
   localparam int PS2_XS    = 4;
   localparam int PS2_YS    = 5;
   localparam int PS2_XO    = 6;
   localparam int PS2_YO    = 7;

   // One-hot packet assembly states; APPLY is the cycle pkt_valid is high.
   typedef enum logic [3:0] {
      WAIT_B0 = 4'b0001,
      WAIT_B1 = 4'b0010,
      WAIT_B2 = 4'b0100,
      APPLY   = 4'b1000
   } trk_state_e;

endpackage

// File: rtl/mouse_pos_tracker_if.sv
// Byte input from the PS/2 receiver and cursor/button outputs of the tracker.
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; rx_data is
// only meaningful in that cycle. pkt_valid/sync_err are one-cycle pulses.
interface mouse_pos_tracker_if import vga_pkg::*; ();

   logic [7:0] rx_data;
   logic       rx_valid;
   coord_t     xpos;
   coord_t     ypos;
   logic       MouseLeft;
   logic       MouseRight;
   logic       pkt_valid;
   logic       sync_err;
   trk_state_e state;

   modport master (
      input  rx_data, rx_valid,
      output xpos, ypos, MouseLeft, MouseRight, pkt_valid, sync_err, state
   );

   modport slave (
      output rx_data, rx_valid,
      input  xpos, ypos, MouseLeft, MouseRight, pkt_valid, sync_err, state
   );

endinterface

// File: rtl/pos_clamp_axis.sv
// One axis of the cursor update: adds or subtracts a 9-bit signed delta and
// clamps the result to 0..max_i.
module pos_clamp_axis
   import vga_pkg::*;
(
   input  coord_t     cur_i,
   input  logic [8:0] delta_i,
   input  logic       sub_i,
   input  coord_t     max_i,
   output coord_t     next_o
);

   logic signed [12:0] cur_s;
   logic signed [12:0] delta_s;
   logic signed [12:0] sum_s;
   logic signed [12:0] max_s;

   always_comb begin
      cur_s   = signed'({1'b0, cur_i});
      delta_s = signed'({{4{delta_i[8]}}, delta_i});
      max_s   = signed'({1'b0, max_i});
      sum_s   = sub_i ? (cur_s - delta_s) : (cur_s + delta_s);
      if (sum_s[12]) begin
         next_o = '0;
      end else if (sum_s > max_s) begin
         next_o = max_i;
      end else begin
         next_o = sum_s[11:0];
      end
   end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets and accumulates their deltas into an
// absolute, clamped cursor position plus button levels.
module mouse_pos_tracker
   import vga_pkg::*;
#(
   parameter int X_MAX   = HOR_PIXELS - 1,
   parameter int Y_MAX   = VER_PIXELS - 1,
   parameter int X_INIT  = 400,
   parameter int Y_INIT  = 300,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic                clk,
   input  logic                rst,
   mouse_pos_tracker_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   trk_state_e       state_q,  state_d;
   logic [7:0]       status_q, status_d;
   logic [7:0]       dx_q,     dx_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   coord_t           xpos_q,   xpos_d;
   coord_t           ypos_q,   ypos_d;
   logic             left_q,   left_d;
   logic             right_q,  right_d;
   logic             pkt_q,    pkt_d;
   logic             serr_q,   serr_d;

   coord_t           x_next;
   coord_t           y_next;

   pos_clamp_axis u_clamp_x (
      .cur_i   (xpos_q),
      .delta_i ({status_q[PS2_XS], dx_q}),
      .sub_i   (1'b0),
      .max_i   (coord_t'(X_MAX)),
      .next_o  (x_next)
   );

   // dy is taken straight from the third byte so the outputs load on the
   // same edge that moves the FSM into APPLY.
   pos_clamp_axis u_clamp_y (
      .cur_i   (ypos_q),
      .delta_i ({status_q[PS2_YS], bus.rx_data}),
      .sub_i   (1'b1),
      .max_i   (coord_t'(Y_MAX)),
      .next_o  (y_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WAIT_B0;
         status_q <= '0;
         dx_q     <= '0;
         cnt_q    <= '0;
         xpos_q   <= coord_t'(X_INIT);
         ypos_q   <= coord_t'(Y_INIT);
         left_q   <= 1'b0;
         right_q  <= 1'b0;
         pkt_q    <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         dx_q     <= dx_d;
         cnt_q    <= cnt_d;
         xpos_q   <= xpos_d;
         ypos_q   <= ypos_d;
         left_q   <= left_d;
         right_q  <= right_d;
         pkt_q    <= pkt_d;
         serr_q   <= serr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      dx_d     = dx_q;
      cnt_d    = cnt_q;
      xpos_d   = xpos_q;
      ypos_d   = ypos_q;
      left_d   = left_q;
      right_d  = right_q;
      pkt_d    = 1'b0;
      serr_d   = 1'b0;

      unique case (state_q)
         WAIT_B0, APPLY: begin
            cnt_d   = '0;
            state_d = WAIT_B0;
            if (bus.rx_valid) begin
               if (bus.rx_data[PS2_SYNC]) begin
                  status_d = bus.rx_data;
                  state_d  = WAIT_B1;
               end else begin
                  serr_d = 1'b1;
               end
            end
         end

         WAIT_B1, WAIT_B2: begin
            if (bus.rx_valid) begin
               cnt_d = '0;
               if (state_q == WAIT_B1) begin
                  dx_d    = bus.rx_data;
                  state_d = WAIT_B2;
               end else begin
                  state_d = APPLY;
                  pkt_d   = 1'b1;
                  left_d  = status_q[PS2_BTN_L];
                  right_d = status_q[PS2_BTN_R];
                  if (!status_q[PS2_XO]) xpos_d = x_next;
                  if (!status_q[PS2_YO]) ypos_d = y_next;
               end
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_B0;
               serr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = WAIT_B0;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.xpos       = xpos_q;
   assign bus.ypos       = ypos_q;
   assign bus.MouseLeft  = left_q;
   assign bus.MouseRight = right_q;
   assign bus.pkt_valid  = pkt_q;
   assign bus.sync_err   = serr_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed bench for mouse_pos_tracker: packet assembly, clamping, overflow,
// sync recovery, timeout and mid-packet reset, with hand-computed results.
module tb_mouse_pos_tracker;
   import vga_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mouse_pos_tracker_if mif ();

   mouse_pos_tracker #(
      .X_MAX   (799),
      .Y_MAX   (599),
      .X_INIT  (400),
      .Y_INIT  (300),
      .TIMEOUT (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif.master)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      mif.rx_data  = b;
      mif.rx_valid = 1'b1;
      tick();
      mif.rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send(b0);
      send(b1);
      send(b2);
   endtask

   task automatic check_out(input string tag, input int x, input int y,
                            input logic l, input logic r, input logic pv, input logic se);
      check({tag, ".xpos"},  32'(mif.xpos), 32'(x));
      check({tag, ".ypos"},  32'(mif.ypos), 32'(y));
      check({tag, ".left"},  32'(mif.MouseLeft), 32'(l));
      check({tag, ".right"}, 32'(mif.MouseRight), 32'(r));
      check({tag, ".pkt"},   32'(mif.pkt_valid), 32'(pv));
      check({tag, ".serr"},  32'(mif.sync_err), 32'(se));
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      mif.rx_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int exp_x;
      int serr_cnt;
      int pkt_cnt;
      rst          = 1'b1;
      mif.rx_valid = 1'b0;
      mif.rx_data  = 8'h00;
      tick();
      tick();
      check_out("reset", 400, 300, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.state", 32'(mif.state), 32'(WAIT_B0));
      rst = 1'b0;

      // basic packet
      send_pkt(8'h09, 8'h05, 8'h03);
      check_out("basic", 405, 297, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("basic.pkt_end", 32'(mif.pkt_valid), 32'd0);

      // large negative dx, clamp at 0, then walk right to the clamp at 799
      do_reset();
      send_pkt(8'h18, 8'h00, 8'h00);
      check_out("neg1", 144, 300, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      send_pkt(8'h18, 8'h00, 8'h00);
      check_out("neg2", 0, 300, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      for (int i = 1; i <= 8; i++) begin
         send_pkt(8'h08, 8'h7F, 8'h00);
         exp_x = (127 * i > 799) ? 799 : 127 * i;
         check($sformatf("walk%0d.xpos", i), 32'(mif.xpos), 32'(exp_x));
         tick();
      end
      check("walk.ypos", 32'(mif.ypos), 32'd300);

      // overflow: X-only, then both axes, then buttons released
      send_pkt(8'h49, 8'h10, 8'h10);
      check_out("ovf_x", 799, 284, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      send_pkt(8'hC9, 8'h10, 8'h10);
      check_out("ovf_xy", 799, 284, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      send_pkt(8'h08, 8'h00, 8'h00);
      check_out("release", 799, 284, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // sync recovery
      do_reset();
      send(8'h00);
      check("sync.serr", 32'(mif.sync_err), 32'd1);
      check("sync.state", 32'(mif.state), 32'(WAIT_B0));
      send(8'h08);
      check("sync.serr_clear", 32'(mif.sync_err), 32'd0);
      send(8'h01);
      send(8'h01);
      check_out("sync.pkt", 401, 299, 1'b0, 1'b0, 1'b1, 1'b0);

      // byte arriving during APPLY: bad first byte, then a good packet
      tick();
      send_pkt(8'h08, 8'h01, 8'h00);
      check_out("apply1", 402, 299, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h00);
      check_out("apply_bad", 402, 299, 1'b0, 1'b0, 1'b0, 1'b1);
      send_pkt(8'h18, 8'hFF, 8'h00);
      check_out("apply2", 401, 299, 1'b0, 1'b0, 1'b1, 1'b0);
      send_pkt(8'h08, 8'h02, 8'h00);
      check_out("apply3", 403, 299, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // timeout after the status byte
      send(8'h08);
      serr_cnt = 0;
      pkt_cnt  = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (mif.sync_err)  serr_cnt++;
         if (mif.pkt_valid) pkt_cnt++;
      end
      check("tmo.serr_count", 32'(serr_cnt), 32'd1);
      check("tmo.pkt_count", 32'(pkt_cnt), 32'd0);
      check("tmo.state", 32'(mif.state), 32'(WAIT_B0));
      check("tmo.xpos", 32'(mif.xpos), 32'd403);
      send_pkt(8'h0A, 8'h00, 8'h00);
      check_out("tmo.next", 403, 299, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();

      // byte arriving on the cycle the counter would expire is accepted
      send(8'h08);
      serr_cnt = 0;
      for (int i = 0; i < 19; i++) begin
         tick();
         if (mif.sync_err) serr_cnt++;
      end
      send(8'h01);
      if (mif.sync_err) serr_cnt++;
      check("edge.serr_count", 32'(serr_cnt), 32'd0);
      check("edge.state", 32'(mif.state), 32'(WAIT_B2));
      send(8'h00);
      check_out("edge.pkt", 404, 299, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // reset in the middle of a packet
      send(8'h09);
      send(8'h05);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_out("midrst", 400, 300, 1'b0, 1'b0, 1'b0, 1'b0);
      check("midrst.state", 32'(mif.state), 32'(WAIT_B0));
      send_pkt(8'h09, 8'h05, 8'h03);
      check_out("midrst.pkt", 405, 297, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
